// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - splits a 32-bit constant into (imm, EOp) beats for the immediate extender
// Optional word-offset encoding (EOp 11) enabled by defining IMM_PACK_WORD_EN.
module imm_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_eop,
  output logic        out_last
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;

  state_e      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic [1:0]  out_eop_q;
  logic [15:0] out_imm_q;
  logic [15:0] lo_q;

  logic [15:0] imm_d;
  logic [1:0]  eop_d;
  logic        last_d;

  // First-beat encoding; the fall-through default is the lui half of lui/ori.
  always_comb begin
    imm_d  = value[31:16];
    eop_d  = 2'b10;
    last_d = 1'b0;
    if (value[31:15] == {17{value[15]}}) begin
      imm_d  = value[15:0];
      eop_d  = 2'b00;
      last_d = 1'b1;
    end else if (value[31:16] == 16'h0000) begin
      imm_d  = value[15:0];
      eop_d  = 2'b01;
      last_d = 1'b1;
    end else if (value[15:0] == 16'h0000) begin
      imm_d  = value[31:16];
      eop_d  = 2'b10;
      last_d = 1'b1;
    end
`ifdef IMM_PACK_WORD_EN
    else if (value[1:0] == 2'b00 && value[31:17] == {15{value[17]}}) begin
      imm_d  = value[17:2];
      eop_d  = 2'b11;
      last_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= 16'h0000;
      out_eop_q   <= 2'b00;
      out_last_q  <= 1'b0;
      lo_q        <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= BEAT1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_imm_q   <= imm_d;
            out_eop_q   <= eop_d;
            out_last_q  <= last_d;
            lo_q        <= value[15:0];
          end
        end
        BEAT1: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              state_q    <= BEAT2;
              out_imm_q  <= lo_q;
              out_eop_q  <= 2'b01;
              out_last_q <= 1'b1;
            end
          end
        end
        BEAT2: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_eop   = out_eop_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - directed-vector bench for imm_pack
// Expectations for 0x0001FFFC follow IMM_PACK_WORD_EN.
module tb_imm_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;

  int vectors;
  int errors;

  logic [19:0] got;
  logic [19:0] exp_beat;

  logic [31:0] sv_val [7];
  logic [1:0]  sv_eop [7];
  logic [15:0] sv_imm [7];

  imm_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_eop   (out_eop),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // got = {valid, eop, imm, last}
  task automatic sample();
    got = {out_valid, out_eop, out_imm, out_last};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    value     = 32'h0;
    tick();
    tick();
    sample();
    vectors++;
    if (got !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", got, 20'h0);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    sv_val[0] = 32'hFFFF8000; sv_eop[0] = 2'b00; sv_imm[0] = 16'h8000;
    sv_val[1] = 32'h00000000; sv_eop[1] = 2'b00; sv_imm[1] = 16'h0000;
    sv_val[2] = 32'h0000ABCD; sv_eop[2] = 2'b01; sv_imm[2] = 16'hABCD;
    sv_val[3] = 32'h12340000; sv_eop[3] = 2'b10; sv_imm[3] = 16'h1234;
    sv_val[4] = 32'h00008000; sv_eop[4] = 2'b01; sv_imm[4] = 16'h8000;
    sv_val[5] = 32'h00007FFF; sv_eop[5] = 2'b00; sv_imm[5] = 16'h7FFF;
    sv_val[6] = 32'hFFFE0000; sv_eop[6] = 2'b10; sv_imm[6] = 16'hFFFE;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      value    = sv_val[i];
      tick();
      in_valid = 1'b0;
      value    = 32'hDEAD_BEEF;
      sample();
      exp_beat = {1'b1, sv_eop[i], sv_imm[i], 1'b1};
      vectors++;
      if (got !== exp_beat) begin
        errors++;
        $display("FAIL single_beat[%0d] value %h got %h want %h", i, sv_val[i], got, exp_beat);
      end
      tick();
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL single_done[%0d] valid/ready got %b want 01", i, {out_valid, in_ready});
      end
    end
  endtask

  task automatic test_word_offset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value     = 32'h0001FFFC;
    tick();
    in_valid = 1'b0;
    sample();
`ifdef IMM_PACK_WORD_EN
    exp_beat = {1'b1, 2'b11, 16'h7FFF, 1'b1};
    vectors++;
    if (got !== exp_beat) begin
      errors++;
      $display("FAIL word_beat got %h want %h", got, exp_beat);
    end
`else
    exp_beat = {1'b1, 2'b10, 16'h0001, 1'b0};
    vectors++;
    if (got !== exp_beat) begin
      errors++;
      $display("FAIL word_beat1 got %h want %h", got, exp_beat);
    end
    tick();
    sample();
    exp_beat = {1'b1, 2'b01, 16'hFFFC, 1'b1};
    vectors++;
    if (got !== exp_beat) begin
      errors++;
      $display("FAIL word_beat2 got %h want %h", got, exp_beat);
    end
`endif
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL word_done valid/ready got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    value     = 32'h12345678;
    tick();
    value = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      sample();
      exp_beat = {1'b1, 2'b10, 16'h1234, 1'b0};
      vectors++;
      if (got !== exp_beat || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %h ready %b want %h ready 0", i, got, in_ready, exp_beat);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    sample();
    exp_beat = {1'b1, 2'b01, 16'h5678, 1'b1};
    vectors++;
    if (got !== exp_beat || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_beat2 got %h ready %b want %h ready 0", got, in_ready, exp_beat);
    end
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_done valid/ready got %b want 01", {out_valid, in_ready});
    end
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_ready got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value     = 32'h12345678;
    tick();
    in_valid = 1'b0;
    tick();
    sample();
    exp_beat = {1'b1, 2'b01, 16'h5678, 1'b1};
    vectors++;
    if (got !== exp_beat) begin
      errors++;
      $display("FAIL abort_beat2 got %h want %h", got, exp_beat);
    end
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_reset valid/ready got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_beat got valid %b want 0", out_valid);
    end
    in_valid = 1'b1;
    value    = 32'h00000004;
    tick();
    in_valid = 1'b0;
    sample();
    exp_beat = {1'b1, 2'b00, 16'h0004, 1'b1};
    vectors++;
    if (got !== exp_beat) begin
      errors++;
      $display("FAIL abort_next got %h want %h", got, exp_beat);
    end
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_next_done valid/ready got %b want 01", {out_valid, in_ready});
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single();
    test_word_offset();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
